shift_register: RTL and testbench
=================================

SHIFT_REGISTER -- requirements
Module: shift_register

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of the data path and of every stage.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: data_in  input  WIDTH  serial data sampled into stage 1.
REQ-005 Port: data_out  output  WIDTH  registered output of stage 4, the last stage.
REQ-006 The block SHALL have no other ports, and data_out SHALL be driven directly by a flop with no combinational path from any input.

Function
REQ-007 The block SHALL be a fixed 4-stage serial-in/serial-out shift register: stage1 <- data_in, stage2 <- stage1, stage3 <- stage2, stage4 (data_out) <- stage3, all on the same rising clk edge.
REQ-008 The three internal stage outputs SHALL be named temp1_out, temp2_out and temp3_out, each WIDTH bits, so benches can probe them hierarchically.
REQ-009 Latency: a value present on data_in at rising edge N SHALL appear on temp1_out after edge N, temp2_out after N+1, temp3_out after N+2 and data_out after N+3 (4 edges counting the capture edge).
REQ-010 Every stage SHALL shift on every rising edge while reset_n is high, with no enable, hold or load input.
REQ-011 Data SHALL pass bit-for-bit unmodified, with no inversion, no reordering across the WIDTH bits and no arithmetic.
REQ-012 A data_in change coincident with a rising edge SHALL be treated per standard flop semantics: the value settled before the edge is captured.
REQ-013 Bits shifted out of stage 4 SHALL be discarded.

Reset
REQ-014 When reset_n goes low, temp1_out, temp2_out, temp3_out and data_out SHALL clear to all-zeros immediately, independent of clk.
REQ-015 While reset_n is low, all stages SHALL hold zero and clock edges SHALL have no effect.
REQ-016 The first capture after release SHALL occur at the first rising clk edge at which reset_n is already high.
REQ-017 Reset asserted mid-stream SHALL discard all in-flight data, and no pre-reset value SHALL ever reappear at data_out.

Structure
REQ-018 A shared package shift_register_pkg SHALL hold the constant SR_STAGES = 4 and the reset value constant SR_RESET_VAL = 0.
REQ-019 The block SHALL be built from one sub-module, sr_dff_stage, instantiated 4 times and chained.
REQ-020 sr_dff_stage SHALL be a WIDTH-bit D flop with asynchronous active-low reset to zero and ports clk, reset_n, d and q.
REQ-021 The block SHALL contain no latches and no gated or derived clocks.
REQ-022 The block SHALL include simulation-only checks that data_out equals data_in delayed by 4 clock edges whenever reset_n has been high for at least 4 edges.

Verification
REQ-023 Reset hold: reset_n=0 with data_in toggling for 2 rising edges -> all stages and data_out stay 0 throughout.
REQ-024 Pattern shift: release reset, then drive data_in 1,0,1,1,0 on 5 consecutive edges (clk period 10, edges at 25..65) -> data_out=1 after edge 55 and 0 after edge 65; temp1_out/temp2_out/temp3_out track the pattern at 1/2/3 edges of lag.
REQ-025 Single pulse: one-cycle data_in=1 among zeros -> exactly one 1 travels temp1_out, temp2_out, temp3_out, data_out on 4 successive edges, then all stages return to 0.
REQ-026 Mid-stream reset: load 1,1,1,1 so all stages hold 1, then pulse reset_n low between edges -> all stages read 0 immediately; after release and data_in=0, data_out stays 0.
REQ-027 Wide path: WIDTH=8 with data_in 0xA5 then 0x3C -> data_out shows 0xA5 then 0x3C at 4-edge latency with bits intact.
REQ-028 Random stream: 200 random bits with reset held high -> data_out matches data_in delayed 4 edges on every cycle.

Source files
------------

// File: rtl/shift_register_pkg.sv
// Shared constants for the 4-stage serial-in/serial-out shift register.
package shift_register_pkg;

  // Number of chained flop stages between data_in and data_out.
  localparam int unsigned SR_STAGES = 4;

  // Value every stage takes while reset_n is low.
  localparam int unsigned SR_RESET_VAL = 0;

endpackage

// File: rtl/shift_register_if.sv
// Data bundle for the shift register: the driver side owns data_in, the register side data_out.
interface shift_register_if #(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  modport master (
    output data_in,
    input  data_out
  );

  modport slave (
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/sr_dff_stage.sv
// One WIDTH-bit D flop stage with asynchronous active-low clear.
module sr_dff_stage
  import shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d, q_q;

  // Next state is simply the stage input; no enable or hold path.
  always_comb begin
    q_d = d;
  end

  // Stage register, cleared immediately when reset_n falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= WIDTH'(SR_RESET_VAL);
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_register.sv
// Fixed 4-stage serial-in/serial-out shift register built from chained sr_dff_stage flops.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  // Internal stage outputs, kept under these names for hierarchical probing.
  logic [WIDTH-1:0] temp1_out;
  logic [WIDTH-1:0] temp2_out;
  logic [WIDTH-1:0] temp3_out;

  sr_dff_stage #(
    .WIDTH(WIDTH)
  ) u_stage1 (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (data_in),
    .q      (temp1_out)
  );

  sr_dff_stage #(
    .WIDTH(WIDTH)
  ) u_stage2 (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (temp1_out),
    .q      (temp2_out)
  );

  sr_dff_stage #(
    .WIDTH(WIDTH)
  ) u_stage3 (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (temp2_out),
    .q      (temp3_out)
  );

  // Last stage drives data_out straight from its flop.
  sr_dff_stage #(
    .WIDTH(WIDTH)
  ) u_stage4 (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (temp3_out),
    .q      (data_out)
  );

`ifndef SYNTHESIS
  // Counts edges since reset release, saturating once the pipe is full of post-reset data.
  logic [2:0] warm_d, warm_q;

  // Saturating increment of the warm-up count.
  always_comb begin
    warm_d = warm_q;
    if (warm_q != 3'(SR_STAGES)) begin
      warm_d = warm_q + 3'd1;
    end
  end

  // Warm-up counter register, cleared with the data stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_q <= 3'd0;
    end else begin
      warm_q <= warm_d;
    end
  end

  // Once every stage holds post-reset data, data_out is data_in from SR_STAGES edges earlier.
  a_latency: assert property (@(posedge clk) disable iff (!reset_n)
    (warm_q == 3'(SR_STAGES)) |-> (data_out == $past(data_in, SR_STAGES)));
`endif

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench: a 1-bit and an 8-bit instance share clock and reset.
module tb_shift_register;

  logic clk;
  logic reset_n;

  shift_register_if #(.WIDTH(1)) bus1 ();
  shift_register_if #(.WIDTH(8)) bus8 ();

  shift_register #(
    .WIDTH(1)
  ) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .data_in (bus1.data_in),
    .data_out(bus1.data_out)
  );

  shift_register #(
    .WIDTH(8)
  ) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .data_in (bus8.data_in),
    .data_out(bus8.data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboards: values captured by each instance, oldest first.
  logic [7:0] q1[$];
  logic [7:0] q8[$];

  typedef struct {
    logic       din;
    logic [3:0] exp;  // {temp1_out, temp2_out, temp3_out, data_out}
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_reset();
    q1 = '{8'h00, 8'h00, 8'h00};
    q8 = '{8'h00, 8'h00, 8'h00};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".w1.t1"},  {7'b0, dut1.temp1_out}, 8'h00);
    chk({tag, ".w1.t2"},  {7'b0, dut1.temp2_out}, 8'h00);
    chk({tag, ".w1.t3"},  {7'b0, dut1.temp3_out}, 8'h00);
    chk({tag, ".w1.out"}, {7'b0, bus1.data_out},  8'h00);
    chk({tag, ".w8.t1"},  dut8.temp1_out, 8'h00);
    chk({tag, ".w8.t2"},  dut8.temp2_out, 8'h00);
    chk({tag, ".w8.t3"},  dut8.temp3_out, 8'h00);
    chk({tag, ".w8.out"}, bus8.data_out,  8'h00);
  endtask

  // Drive one edge's worth of data (called away from posedge), compare #1 after the edge.
  task automatic cycle(input string tag, input logic d1, input logic [7:0] d8);
    bus1.data_in = d1;
    bus8.data_in = d8;
    @(posedge clk);
    #1;
    if (reset_n) begin
      q1.push_back({7'b0, d1});
      q8.push_back(d8);
      chk({tag, ".w1.t1"},  {7'b0, dut1.temp1_out}, q1[3]);
      chk({tag, ".w1.t2"},  {7'b0, dut1.temp2_out}, q1[2]);
      chk({tag, ".w1.t3"},  {7'b0, dut1.temp3_out}, q1[1]);
      chk({tag, ".w1.out"}, {7'b0, bus1.data_out},  q1.pop_front());
      chk({tag, ".w8.t1"},  dut8.temp1_out, q8[3]);
      chk({tag, ".w8.t2"},  dut8.temp2_out, q8[2]);
      chk({tag, ".w8.t3"},  dut8.temp3_out, q8[1]);
      chk({tag, ".w8.out"}, bus8.data_out,  q8.pop_front());
    end else begin
      chk_all_zero(tag);
    end
    @(negedge clk);
  endtask

  initial begin
    // Pattern 1,0,1,1,0, flush, then a single pulse; stages start at zero after release.
    tbl[0]  = '{1'b1, 4'b1000};
    tbl[1]  = '{1'b0, 4'b0100};
    tbl[2]  = '{1'b1, 4'b1010};
    tbl[3]  = '{1'b1, 4'b1101};
    tbl[4]  = '{1'b0, 4'b0110};
    tbl[5]  = '{1'b0, 4'b0011};
    tbl[6]  = '{1'b0, 4'b0001};
    tbl[7]  = '{1'b0, 4'b0000};
    tbl[8]  = '{1'b0, 4'b0000};
    tbl[9]  = '{1'b1, 4'b1000};
    tbl[10] = '{1'b0, 4'b0100};
    tbl[11] = '{1'b0, 4'b0010};
    tbl[12] = '{1'b0, 4'b0001};
    tbl[13] = '{1'b0, 4'b0000};

    reset_n      = 1'b0;
    bus1.data_in = 1'b0;
    bus8.data_in = 8'h00;
    sb_reset();
    #1;
    chk_all_zero("por");

    // Reset hold with toggling data across edges 5 and 15.
    cycle("rst_hold0", 1'b1, 8'hFF);
    cycle("rst_hold1", 1'b0, 8'h5A);

    // Release at t=20; first capture at edge 25.
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cycle("tbl", tbl[i].din, {8{tbl[i].din}});
      chk($sformatf("tbl[%0d].t1", i),  {7'b0, dut1.temp1_out}, {7'b0, tbl[i].exp[3]});
      chk($sformatf("tbl[%0d].t2", i),  {7'b0, dut1.temp2_out}, {7'b0, tbl[i].exp[2]});
      chk($sformatf("tbl[%0d].t3", i),  {7'b0, dut1.temp3_out}, {7'b0, tbl[i].exp[1]});
      chk($sformatf("tbl[%0d].out", i), {7'b0, bus1.data_out},  {7'b0, tbl[i].exp[0]});
    end

    // Wide path: 0xA5 then 0x3C emerge intact four edges after capture.
    cycle("wide", 1'b0, 8'hA5);
    cycle("wide", 1'b0, 8'h3C);
    cycle("wide", 1'b0, 8'h00);
    cycle("wide", 1'b0, 8'h00);
    chk("wide.a5", bus8.data_out, 8'hA5);
    cycle("wide", 1'b0, 8'h00);
    chk("wide.3c", bus8.data_out, 8'h3C);
    cycle("wide", 1'b0, 8'h00);
    chk("wide.flush", bus8.data_out, 8'h00);

    // Mid-stream reset: fill with ones, pulse reset between edges.
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 8'hFF);
    chk("fill.w1.out", {7'b0, bus1.data_out}, 8'h01);
    chk("fill.w8.t1",  dut8.temp1_out, 8'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    sb_reset();
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle("post_rst", 1'b0, 8'h00);
    chk("post_rst.w1.out", {7'b0, bus1.data_out}, 8'h00);

    // Random stream with reset held high.
    for (int i = 0; i < 200; i++) begin
      cycle("rand", 1'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
